quicksort_rx_checker: RTL and testbench

QUICKSORT_RX_CHECKER -- requirements
Module: quicksort_rx_checker

---
 rtl/quicksort_rx_checker.sv | 129 ++++++++++++
 tb/tb_quicksort_rx_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quicksort_rx_checker.sv
// Sorted-stream checker: consumes bursts from the sorter dequeue port and
// issues one registered report per burst (count, first/last word,
// ordering and length violations).
module quicksort_rx_checker #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [W-1:0]         in_dat,
    input  logic                 in_last,
    output logic                 in_rdy,
    output logic                 rpt_vld,
    input  logic                 rpt_rdy,
    output logic [$clog2(N):0]   rpt_cnt,
    output logic [W-1:0]         rpt_min,
    output logic [W-1:0]         rpt_max,
    output logic                 rpt_err_order,
    output logic [$clog2(N)-1:0] rpt_err_idx,
    output logic                 rpt_err_len
);

    localparam int CW = $clog2(N) + 1;
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        REPORT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    min_q, min_d;
    logic [W-1:0]    max_q, max_d;
    logic [W-1:0]    prev_q, prev_d;
    logic            eo_q, eo_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            el_q, el_d;
    logic            accept;

    // Ready and report-valid come from the registered state only.
    assign in_rdy  = (state_q != REPORT);
    assign rpt_vld = (state_q == REPORT);
    assign accept  = in_vld && in_rdy;

    // Next-state logic for the burst framing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_last ? REPORT : RECV;
            RECV:    if (accept && in_last) state_d = REPORT;
            REPORT:  if (rpt_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst statistics: the first beat (taken in IDLE) reloads everything,
    // later beats accumulate; all fields hold while the report is pending.
    always_comb begin
        cnt_d  = cnt_q;
        min_d  = min_q;
        max_d  = max_q;
        prev_d = prev_q;
        eo_d   = eo_q;
        idx_d  = idx_q;
        el_d   = el_q;
        if (accept) begin
            if (state_q == IDLE) begin
                cnt_d  = CW'(1);
                min_d  = in_dat;
                max_d  = in_dat;
                prev_d = in_dat;
                eo_d   = 1'b0;
                idx_d  = '0;
                el_d   = 1'b0;
            end else begin
                max_d  = in_dat;
                prev_d = in_dat;
                if (cnt_q == CNT_MAX) begin
                    el_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (in_dat < prev_q) begin
                    eo_d = 1'b1;
                    // cnt_q is the zero-based index of this word; indices
                    // past N-1 cannot be represented and leave idx alone.
                    if (!eo_q && (cnt_q < CNT_MAX)) begin
                        idx_d = cnt_q[IW-1:0];
                    end
                end
            end
        end
    end

    // State and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            prev_q  <= '0;
            eo_q    <= 1'b0;
            idx_q   <= '0;
            el_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            prev_q  <= prev_d;
            eo_q    <= eo_d;
            idx_q   <= idx_d;
            el_q    <= el_d;
        end
    end

    assign rpt_cnt       = cnt_q;
    assign rpt_min       = min_q;
    assign rpt_max       = max_q;
    assign rpt_err_order = eo_q;
    assign rpt_err_idx   = idx_q;
    assign rpt_err_len   = el_q;

endmodule

// File: tb/tb_quicksort_rx_checker.sv
// Bench for quicksort_rx_checker: table of directed bursts, hand-written
// reset/back-pressure sequences and random bursts against a list model.
module tb_quicksort_rx_checker;

    localparam int N = 16;
    localparam int W = 32;

    typedef struct packed {
        logic [4:0]  cnt;
        logic [31:0] mn;
        logic [31:0] mx;
        logic        eo;
        logic [3:0]  ei;
        logic        el;
    } rep_t;

    typedef struct {
        int                len;
        logic [19:0][31:0] w;
        rep_t              exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [31:0] in_dat;
    logic        in_last;
    logic        in_rdy;
    logic        rpt_vld;
    logic        rpt_rdy;
    logic [4:0]  rpt_cnt;
    logic [31:0] rpt_min;
    logic [31:0] rpt_max;
    logic        rpt_err_order;
    logic [3:0]  rpt_err_idx;
    logic        rpt_err_len;

    int   vectors = 0;
    int   miscompares = 0;
    int   rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
    logic inrep = 1'b0;     // bench's view: DUT should be in REPORT this cycle
    rep_t expq[$];
    vec_t tbl[8];

    quicksort_rx_checker #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat),
        .in_last(in_last), .in_rdy(in_rdy), .rpt_vld(rpt_vld),
        .rpt_rdy(rpt_rdy), .rpt_cnt(rpt_cnt), .rpt_min(rpt_min),
        .rpt_max(rpt_max), .rpt_err_order(rpt_err_order),
        .rpt_err_idx(rpt_err_idx), .rpt_err_len(rpt_err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: report of a burst computed directly from the word list.
    function automatic rep_t model(input int len, input logic [19:0][31:0] w);
        rep_t r;
        r.cnt = (len > N) ? 5'(N) : 5'(len);
        r.mn  = w[0];
        r.mx  = w[len-1];
        r.eo  = 1'b0;
        r.ei  = '0;
        r.el  = (len > N);
        for (int i = 1; i < len; i++) begin
            if (!r.eo && (w[i] < w[i-1])) begin
                r.eo = 1'b1;
                r.ei = (i < N) ? 4'(i) : 4'd0;
            end
        end
        return r;
    endfunction

    // Report consumer ready.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rpt_rdy = 1'b0;
            1:       rpt_rdy = 1'b1;
            default: rpt_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Mid-cycle monitor: ready/valid versus expected phase, report scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            inrep = 1'b0;
        end else begin
            chk("in_rdy_phase", in_rdy, !inrep);
            chk("rpt_vld_phase", rpt_vld, inrep);
            if (rpt_vld && rpt_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rpt", 1, 0);
                end else begin
                    rep_t e;
                    e = expq.pop_front();
                    chk("rpt_cnt", rpt_cnt, e.cnt);
                    chk("rpt_min", rpt_min, e.mn);
                    chk("rpt_max", rpt_max, e.mx);
                    chk("rpt_err_order", rpt_err_order, e.eo);
                    chk("rpt_err_idx", rpt_err_idx, e.ei);
                    chk("rpt_err_len", rpt_err_len, e.el);
                end
            end
            if (inrep && rpt_rdy)
                inrep = 1'b0;
            else if (!inrep && in_vld && in_last)
                inrep = 1'b1;
        end
    end

    // Presents one burst, honouring in_rdy, with optional bubbles; leaves
    // in_vld high afterwards when keep is set (back-to-back streaming).
    task automatic send_burst(input int len, input logic [19:0][31:0] w,
                              input logic keep, input int bubble_pct);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < len) begin
            if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
                in_vld = 1'b0;
            end else begin
                in_vld  = 1'b1;
                in_dat  = w[i];
                in_last = (i == len - 1);
            end
            @(negedge clk);
            acc = in_vld && in_rdy;
            @(posedge clk);
            #2;
            if (acc) i++;
            guard++;
            if (guard > 2000) begin
                chk("burst_timeout", 1, 0);
                return;
            end
        end
        in_vld = keep;
        @(negedge clk);
        chk("rpt_latency", rpt_vld, 1);
        chk("in_rdy_report", in_rdy, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int g = 0;
        while (expq.size() != 0 && g < 200) begin
            @(posedge clk);
            #2;
            g++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = 1'b1;          // must be ignored during reset
        in_dat  = 32'hDEAD_BEEF;
        in_last = 1'b1;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        in_vld = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("rst_rpt_vld", rpt_vld, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_cnt", rpt_cnt, 0);
        chk("rst_min", rpt_min, 0);
        chk("rst_max", rpt_max, 0);
        chk("rst_err", {rpt_err_order, rpt_err_idx, rpt_err_len}, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [19:0][31:0] w;
        int   len;
        // Directed table: {length, words, expected report}.
        w = '0; w[0] = 3; w[1] = 7; w[2] = 7; w[3] = 20;
        tbl[0] = '{4, w, '{cnt:5'd4, mn:32'd3, mx:32'd20, eo:1'b0, ei:4'd0, el:1'b0}};
        w = '0; w[0] = 5; w[1] = 9; w[2] = 4; w[3] = 2;
        tbl[1] = '{4, w, '{cnt:5'd4, mn:32'd5, mx:32'd2, eo:1'b1, ei:4'd2, el:1'b0}};
        w = '0; for (int i = 0; i < 17; i++) w[i] = 32'(i);
        tbl[2] = '{17, w, '{cnt:5'd16, mn:32'd0, mx:32'd16, eo:1'b0, ei:4'd0, el:1'b1}};
        w = '0; w[0] = 4; w[1] = 4; w[2] = 4;
        tbl[3] = '{3, w, '{cnt:5'd3, mn:32'd4, mx:32'd4, eo:1'b0, ei:4'd0, el:1'b0}};
        w = '0; for (int i = 0; i < 16; i++) w[i] = 32'(i); w[16] = 3; w[17] = 2;
        tbl[4] = '{18, w, '{cnt:5'd16, mn:32'd0, mx:32'd2, eo:1'b1, ei:4'd0, el:1'b1}};
        w = '0; w[0] = 10; w[1] = 10; w[2] = 9;
        tbl[5] = '{3, w, '{cnt:5'd3, mn:32'd10, mx:32'd9, eo:1'b1, ei:4'd2, el:1'b0}};
        w = '0; for (int i = 0; i < 16; i++) w[i] = 32'(i);
        tbl[6] = '{16, w, '{cnt:5'd16, mn:32'd0, mx:32'd15, eo:1'b0, ei:4'd0, el:1'b0}};
        w = '0; for (int i = 0; i < 15; i++) w[i] = 32'(i); w[15] = 1;
        tbl[7] = '{16, w, '{cnt:5'd16, mn:32'd0, mx:32'd1, eo:1'b1, ei:4'd15, el:1'b0}};

        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        do_reset();

        // Directed bursts streamed back-to-back with in_vld held high.
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            expq.push_back(tbl[k].exp);
            send_burst(tbl[k].len, tbl[k].w, (k != 7), 0);
        end
        drain();

        // Single max-value word with report back-pressure.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        w = '0; w[0] = 32'hFFFF_FFFF;
        expq.push_back('{cnt:5'd1, mn:32'hFFFF_FFFF, mx:32'hFFFF_FFFF, eo:1'b0, ei:4'd0, el:1'b0});
        send_burst(1, w, 1'b1, 0);
        in_dat = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rpt_vld", rpt_vld, 1);
            chk("stall_in_rdy", in_rdy, 0);
            chk("stall_cnt", rpt_cnt, 1);
            chk("stall_min", rpt_min, 32'hFFFF_FFFF);
            chk("stall_max", rpt_max, 32'hFFFF_FFFF);
            @(posedge clk);
            #2;
        end
        in_vld = 1'b0;
        rdy_mode = 1;
        drain();

        // Reset in the middle of a burst discards it.
        for (int c = 0; c < 2; c++) begin
            in_vld = 1'b1; in_dat = 32'(50 + c); in_last = 1'b0;
            @(posedge clk);
            #2;
        end
        do_reset();
        w = '0; w[0] = 1; w[1] = 2;
        expq.push_back('{cnt:5'd2, mn:32'd1, mx:32'd2, eo:1'b0, ei:4'd0, el:1'b0});
        send_burst(2, w, 1'b0, 0);
        drain();

        // Reset while a report is pending discards the report.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        w = '0; w[0] = 42;
        expq.push_back('{cnt:5'd1, mn:32'd42, mx:32'd42, eo:1'b0, ei:4'd0, el:1'b0});
        send_burst(1, w, 1'b0, 0);
        do_reset();
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        #2;

        // Random bursts with random back-pressure and bubbles.
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 20);
            w = '0;
            w[0] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1000));
            for (int i = 1; i < len; i++) begin
                if ($urandom_range(0, 99) < 12 && w[i-1] != 0)
                    w[i] = w[i-1] - 32'($urandom_range(1, 3));
                else
                    w[i] = w[i-1] + 32'($urandom_range(0, 5));
            end
            expq.push_back(model(len, w));
            send_burst(len, w, (k != 39) && ($urandom_range(0, 1) == 1), 20);
        end
        in_vld = 1'b0;
        rdy_mode = 1;
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
